// File: rtl/serializer.sv
// serializer: shifts the top N bits of a captured parallel word out MSB first, one per clock.
module serializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = 4
) (
    input  logic              clk,
    input  logic              i_arst,
    input  logic [DATA_W-1:0] i_data,
    input  logic [MOD_W-1:0]  i_data_mod,
    input  logic              i_data_val,
    output logic              o_ser_data,
    output logic              o_ser_data_val,
    output logic              o_busy
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;
    logic [DATA_W-1:0] sreg, sreg_nxt;
    logic [MOD_W:0] cnt, cnt_nxt;
    logic [MOD_W:0] n_eff;
    logic accept;
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end
    assign n_eff  = (i_data_mod == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, i_data_mod};
    assign accept = (state == IDLE) && i_data_val && (n_eff > (MOD_W+1)'(2));
    // The register is cleared on exit so its MSB reads 0 throughout IDLE.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        if (state == IDLE) begin
            state_nxt = accept ? SHIFT : IDLE;
            sreg_nxt  = accept ? i_data : sreg;
            cnt_nxt   = accept ? n_eff : cnt;
        end else begin
            state_nxt = (cnt == (MOD_W+1)'(1)) ? IDLE : SHIFT;
            sreg_nxt  = (cnt == (MOD_W+1)'(1)) ? '0 : {sreg[DATA_W-2:0], 1'b0};
            cnt_nxt   = cnt - (MOD_W+1)'(1);
        end
    end
    always_comb begin
        o_busy         = (state == SHIFT);
        o_ser_data_val = (state == SHIFT);
        o_ser_data     = sreg[DATA_W-1];
    end
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed and random stimulus against a queue-of-expected-bits model.
module tb_serializer;
    localparam int DW = 16;
    localparam int MW = 4;
    logic clk = 0;
    logic i_arst = 1;
    logic [DW-1:0] i_data = '0;
    logic [MW-1:0] i_data_mod = '0;
    logic i_data_val = 0;
    logic o_ser_data, o_ser_data_val, o_busy;
    int n_pass = 0;
    int n_total = 0;
    bit q[$];
    serializer #(.DATA_W(DW), .MOD_W(MW)) dut (
        .clk(clk), .i_arst(i_arst), .i_data(i_data), .i_data_mod(i_data_mod),
        .i_data_val(i_data_val), .o_ser_data(o_ser_data),
        .o_ser_data_val(o_ser_data_val), .o_busy(o_busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic check_outputs(input string tag);
        bit b = (q.size() != 0);
        chk({tag, ".busy"}, {31'd0, o_busy}, {31'd0, b});
        chk({tag, ".val"}, {31'd0, o_ser_data_val}, {31'd0, b});
        chk({tag, ".data"}, {31'd0, o_ser_data}, {31'd0, b ? q[0] : 1'b0});
    endtask
    // One clock: present inputs, advance the model at the edge, then check.
    task automatic step(input string tag, input bit val, input logic [DW-1:0] d, input logic [MW-1:0] m);
        int n;
        i_data_val = val;
        i_data = d;
        i_data_mod = m;
        @(posedge clk);
        n = (m == 0) ? DW : int'(m);
        if (q.size() != 0) void'(q.pop_front());
        else if (val && n >= 3)
            for (int i = 0; i < n; i++) q.push_back(d[DW-1-i]);
        #1;
        i_data_val = 0;
        check_outputs(tag);
    endtask
    task automatic idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) step(tag, 0, '0, '0);
    endtask
    initial begin
        int busy_cnt;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        i_arst = 0;
        idle("post_reset", 2);
        step("full", 1, 16'hA5F0, 0);
        idle("full", 18);
        step("partial", 1, 16'hB800, 5);
        idle("partial", 7);
        step("illegal1", 1, 16'hFFFF, 1);
        step("illegal2", 1, 16'hFFFF, 2);
        step("min_after_illegal", 1, 16'hE000, 3);
        idle("min_after_illegal", 4);
        step("busy_ign", 1, 16'hFFFF, 0);
        busy_cnt = 0;
        for (int j = 1; j <= 16; j++) begin
            busy_cnt += int'(o_busy);
            step("busy_ign", (j == 3) || (j == 16), 16'h0000, 4);
        end
        busy_cnt += int'(o_busy);
        chk("busy_ign.len", busy_cnt, 16);
        step("after_busy", 1, 16'h0000, 4);
        idle("after_busy", 6);
        step("min_len", 1, 16'h4000, 3);
        idle("min_len", 5);
        step("mid_reset", 1, 16'hFFFF, 0);
        idle("mid_reset", 4);
        #2 i_arst = 1;
        #1;
        q.delete();
        chk("async_rst.busy", {31'd0, o_busy}, 0);
        chk("async_rst.val", {31'd0, o_ser_data_val}, 0);
        chk("async_rst.data", {31'd0, o_ser_data}, 0);
        @(posedge clk);
        #1 i_arst = 0;
        check_outputs("rst_release");
        idle("rst_release", 5);
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(2) == 0), DW'($urandom), MW'($urandom));
        idle("drain", 20);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
